// File: rtl/axis_fifo_pkg.sv
// -----------------------------------------------------------------------------
// axis_fifo_pkg
// Shared definitions for the AXI4-Stream synchronous FIFO:
//   - axis_beat_t  : beat layout (tdata, tstrb, tkeep, tlast, tid, tdest, tuser)
//                    at the default widths; axis_sync_fifo mirrors this field
//                    order with its own parameter widths.
//   - beat_width() : total stored bits per beat for a given width set.
//   - depth_is_legal() : DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
package axis_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32'd32;
  localparam int unsigned DEF_ID_WIDTH   = 32'd1;
  localparam int unsigned DEF_DEST_WIDTH = 32'd1;
  localparam int unsigned DEF_USER_WIDTH = 32'd1;

  // Beat layout; MSB first: data, strb, keep, last, id, dest, user.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0]     data;
    logic [DEF_DATA_WIDTH/8-1:0]   strb;
    logic [DEF_DATA_WIDTH/8-1:0]   keep;
    logic                          last;
    logic [DEF_ID_WIDTH-1:0]       id;
    logic [DEF_DEST_WIDTH-1:0]     dest;
    logic [DEF_USER_WIDTH-1:0]     user;
  } axis_beat_t;

  function automatic int unsigned beat_width(input int unsigned data_w,
                                             input int unsigned id_w,
                                             input int unsigned dest_w,
                                             input int unsigned user_w);
    return data_w + 32'd2 * (data_w / 32'd8) + 32'd1 + id_w + dest_w + user_w;
  endfunction

  function automatic bit depth_is_legal(input int unsigned depth);
    return (depth >= 32'd2) && ((depth & (depth - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/axis_if.sv
// -----------------------------------------------------------------------------
// axis_if
// AXI4-Stream bundle. master drives tvalid and payload and receives tready;
// slave is the mirror image. tstrb/tkeep are one bit per data byte.
// -----------------------------------------------------------------------------
interface axis_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
                  input  tready);
  modport slave  (input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
                  output tready);
endinterface

// File: rtl/axis_fifo_ram.sv
// -----------------------------------------------------------------------------
// axis_fifo_ram
// DEPTH x WIDTH storage, one synchronous write port, one asynchronous read
// port. Contents are deliberately not reset.
//   i_clk    : write clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data (combinational from i_raddr)
// -----------------------------------------------------------------------------
module axis_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port: store one beat per accepted transfer.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axis_sync_fifo.sv
// -----------------------------------------------------------------------------
// axis_sync_fifo
// Single-clock first-word fall-through AXI4-Stream FIFO.
//   aclk       : clock, rising edge
//   aresetn    : asynchronous active-low reset
//   s_axis     : ingress stream (tready = !full, registered)
//   m_axis     : egress stream
//   fill_level : beats stored (registered)
//   full/empty : registered status flags
// Build option: AXIS_FIFO_PACKET_MODE_EN selects store-and-forward; m_axis
// tvalid then requires a complete packet in storage, or a full FIFO so
// packets longer than DEPTH still flow.
// -----------------------------------------------------------------------------
module axis_sync_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  axis_if.slave                    s_axis,
  axis_if.master                   m_axis,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int KW = DATA_WIDTH / 8;
  localparam int BW = int'(beat_width(DATA_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH));

  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_MAX  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  if (!depth_is_legal(DEPTH)) begin : g_depth_check
    $error("axis_sync_fifo: DEPTH must be a power of two and at least 2");
  end

  // Same field order as axis_beat_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KW-1:0]         strb;
    logic [KW-1:0]         keep;
    logic                  last;
    logic [ID_WIDTH-1:0]   id;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_s_ready;
  logic          r_m_valid;
  logic          w_wr;
  logic          w_rd;
  logic [AW:0]   w_count_nxt;
  logic          w_m_valid_nxt;
  beat_t         w_wr_beat;
  beat_t         w_rd_beat;

  assign w_wr = s_axis.tvalid & r_s_ready;
  assign w_rd = r_m_valid & m_axis.tready;

  assign w_wr_beat = '{data: s_axis.tdata, strb: s_axis.tstrb, keep: s_axis.tkeep,
                       last: s_axis.tlast, id: s_axis.tid, dest: s_axis.tdest,
                       user: s_axis.tuser};

  axis_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (BW)
  ) u_ram (
    .i_clk   (aclk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_beat),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_beat)
  );

  // Next fill level: write-only +1, read-only -1, both or neither unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [AW:0] r_pkt_cnt;
  logic [AW:0] w_pkt_cnt_nxt;

  // Next count of complete packets held (tlast beats stored).
  always_comb begin
    w_pkt_cnt_nxt = r_pkt_cnt;
    case ({w_wr & w_wr_beat.last, w_rd & w_rd_beat.last})
      2'b10:   w_pkt_cnt_nxt = r_pkt_cnt + CNT_ONE;
      2'b01:   w_pkt_cnt_nxt = r_pkt_cnt - CNT_ONE;
      default: w_pkt_cnt_nxt = r_pkt_cnt;
    endcase
  end

  // Packet counter register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_pkt_cnt <= CNT_ZERO;
    end else begin
      r_pkt_cnt <= w_pkt_cnt_nxt;
    end
  end

  // The full term is the cut-through escape for packets longer than DEPTH.
  assign w_m_valid_nxt = (w_pkt_cnt_nxt != CNT_ZERO) || (w_count_nxt == CNT_MAX);
`else
  assign w_m_valid_nxt = (w_count_nxt != CNT_ZERO);
`endif

  // Pointers, fill level and all handshake/status flags.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr  <= {AW{1'b0}};
      r_rd_ptr  <= {AW{1'b0}};
      r_count   <= CNT_ZERO;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count   <= w_count_nxt;
      r_full    <= (w_count_nxt == CNT_MAX);
      r_empty   <= (w_count_nxt == CNT_ZERO);
      // Registered from the next fill level, so a read while full only
      // reopens the input on the following cycle.
      r_s_ready <= (w_count_nxt != CNT_MAX);
      r_m_valid <= w_m_valid_nxt;
    end
  end

  assign s_axis.tready = r_s_ready;
  assign m_axis.tvalid = r_m_valid;
  assign m_axis.tdata  = w_rd_beat.data;
  assign m_axis.tstrb  = w_rd_beat.strb;
  assign m_axis.tkeep  = w_rd_beat.keep;
  assign m_axis.tlast  = w_rd_beat.last;
  assign m_axis.tid    = w_rd_beat.id;
  assign m_axis.tdest  = w_rd_beat.dest;
  assign m_axis.tuser  = w_rd_beat.user;
  assign fill_level    = r_count;
  assign full          = r_full;
  assign empty         = r_empty;

endmodule

// File: tb/tb_axis_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_axis_sync_fifo
// Self-checking bench for axis_sync_fifo (DEPTH=16, 32-bit data). A queue of
// beats models the FIFO; handshakes and flags are derived from its size and
// the store-and-forward rule when AXIS_FIFO_PACKET_MODE_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_sync_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
`ifdef AXIS_FIFO_PACKET_MODE_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [0:0]  id;
    logic [0:0]  dest;
    logic [0:0]  user;
  } beat_t;

  logic       aclk    = 1'b0;
  logic       aresetn = 1'b0;
  logic [4:0] fill_level;
  logic       full;
  logic       empty;
  logic       s_valid = 1'b0;
  logic       m_ready = 1'b0;
  beat_t      in_beat = '0;
  beat_t      out_beat;

  axis_if #(.DATA_WIDTH(DW), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) s_if ();
  axis_if #(.DATA_WIDTH(DW), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) m_if ();

  assign s_if.tvalid = s_valid;
  assign s_if.tdata  = in_beat.data;
  assign s_if.tstrb  = in_beat.strb;
  assign s_if.tkeep  = in_beat.keep;
  assign s_if.tlast  = in_beat.last;
  assign s_if.tid    = in_beat.id;
  assign s_if.tdest  = in_beat.dest;
  assign s_if.tuser  = in_beat.user;
  assign m_if.tready = m_ready;
  assign out_beat    = {m_if.tdata, m_if.tstrb, m_if.tkeep, m_if.tlast,
                        m_if.tid, m_if.tdest, m_if.tuser};

  axis_sync_fifo #(
    .DATA_WIDTH (DW),
    .ID_WIDTH   (1),
    .DEST_WIDTH (1),
    .USER_WIDTH (1),
    .DEPTH      (DEPTH)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .fill_level (fill_level),
    .full       (full),
    .empty      (empty)
  );

  always #5 aclk = ~aclk;

  beat_t mdl_q[$];
  bit    mdl_ready = 1'b0;
  int    checks = 0;
  int    errors = 0;

  function automatic int mdl_lasts();
    int n = 0;
    foreach (mdl_q[i]) if (mdl_q[i].last) n++;
    return n;
  endfunction

  function automatic bit mdl_valid();
    if (PKT) return (mdl_lasts() > 0) || (mdl_q.size() == DEPTH);
    else     return mdl_q.size() > 0;
  endfunction

  function automatic beat_t rand_beat(input bit last);
    beat_t b;
    b.data = $urandom;
    b.strb = 4'($urandom);
    b.keep = 4'($urandom);
    b.last = last;
    b.id   = 1'($urandom);
    b.dest = 1'($urandom);
    b.user = 1'($urandom);
    return b;
  endfunction

  // Advance one clock; the model applies the transfers the rules allow.
  task automatic tick();
    bit    wr;
    bit    rd;
    beat_t b;
    wr = s_valid && mdl_ready;
    rd = mdl_valid() && m_ready;
    b  = in_beat;
    @(posedge aclk);
    if (!aresetn) begin
      mdl_q.delete();
      mdl_ready = 1'b0;
    end else begin
      if (rd) void'(mdl_q.pop_front());
      if (wr) mdl_q.push_back(b);
      mdl_ready = (mdl_q.size() != DEPTH);
    end
    #1;
  endtask

  task automatic test_reset();
    s_valid = 1'b0; m_ready = 1'b0; in_beat = '0; aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_if.tvalid); end
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", s_if.tready); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
    aresetn = 1'b1;
    mdl_q.delete(); mdl_ready = 1'b0;
    tick();
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL reset_release_tready: got %b want 1", s_if.tready); end
  endtask

  task automatic test_single();
    beat_t b;
    b = '{data: 32'hA5A5_0001, strb: 4'hF, keep: 4'hF, last: 1'b1, id: 1'b1, dest: 1'b0, user: 1'b1};
    in_beat = b; s_valid = 1'b1; m_ready = 1'b0;
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL single_pre_tvalid: got %b want 0", m_if.tvalid); end
    tick();
    s_valid = 1'b0;
    checks++; if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL single_tvalid: got %b want 1", m_if.tvalid); end
    checks++; if (out_beat !== b) begin errors++; $display("FAIL single_beat: got %h want %h", out_beat, b); end
    checks++; if (fill_level !== 5'd1) begin errors++; $display("FAIL single_fill: got %0d want 1", fill_level); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++; if (empty !== 1'b1 || m_if.tvalid !== 1'b0) begin errors++; $display("FAIL single_drain: got empty=%b tvalid=%b want 1/0", empty, m_if.tvalid); end
  endtask

  task automatic test_full_and_read();
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_beat = rand_beat(i == DEPTH - 1); s_valid = 1'b1;
      tick();
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", full); end
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL full_tready: got %b want 0", s_if.tready); end
    checks++; if (fill_level !== 5'd16) begin errors++; $display("FAIL full_fill: got %0d want 16", fill_level); end
    in_beat = rand_beat(1'b1);
    tick();
    checks++; if (fill_level !== 5'd16) begin errors++; $display("FAIL full_17th_rejected: got %0d want 16", fill_level); end
    m_ready = 1'b1;
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL full_read_cycle_tready: got %b want 0", s_if.tready); end
    checks++; if (out_beat !== mdl_q[0]) begin errors++; $display("FAIL full_head: got %h want %h", out_beat, mdl_q[0]); end
    tick();
    m_ready = 1'b0; s_valid = 1'b0;
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL full_next_tready: got %b want 1", s_if.tready); end
    checks++; if (fill_level !== 5'd15) begin errors++; $display("FAIL full_after_read_fill: got %0d want 15", fill_level); end
    m_ready = 1'b1;
    for (int n = 0; n < 40 && mdl_q.size() > 0; n++) begin
      checks++; if (m_if.tvalid !== mdl_valid()) begin errors++; $display("FAIL drain_tvalid: got %b want %b", m_if.tvalid, mdl_valid()); end
      if (mdl_valid()) begin
        checks++; if (out_beat !== mdl_q[0]) begin errors++; $display("FAIL drain_beat: got %h want %h", out_beat, mdl_q[0]); end
      end
      tick();
    end
    m_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", empty); end
  endtask

  task automatic test_stream();
    beat_t b;
    m_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      b = '0; b.data = 32'(i); b.strb = 4'hF; b.keep = 4'hF; b.last = 1'b1;
      in_beat = b; s_valid = 1'b1;
      tick();
      checks++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'(i)) begin errors++; $display("FAIL stream_beat%0d: got v=%b d=%0d want v=1 d=%0d", i, m_if.tvalid, m_if.tdata, i); end
      checks++; if (fill_level !== 5'd1) begin errors++; $display("FAIL stream_fill%0d: got %0d want 1", i, fill_level); end
    end
    s_valid = 1'b0;
    tick();
    m_ready = 1'b0;
    checks++; if (empty !== 1'b1 || m_if.tvalid !== 1'b0) begin errors++; $display("FAIL stream_end: got empty=%b tvalid=%b want 1/0", empty, m_if.tvalid); end
  endtask

`ifdef AXIS_FIFO_PACKET_MODE_EN
  task automatic test_packet_mode();
    logic [31:0] exp_d [4];
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_beat = rand_beat(i == 3); exp_d[i] = in_beat.data; s_valid = 1'b1;
      tick();
      checks++; if (m_if.tvalid !== (i == 3)) begin errors++; $display("FAIL pkt_tvalid_beat%0d: got %b want %b", i, m_if.tvalid, (i == 3)); end
    end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== exp_d[i]) begin errors++; $display("FAIL pkt_out%0d: got v=%b d=%h want v=1 d=%h", i, m_if.tvalid, m_if.tdata, exp_d[i]); end
      tick();
    end
    m_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pkt_empty: got %b want 1", empty); end
  endtask
`else
  task automatic test_cut_through();
    m_ready = 1'b0;
    in_beat = rand_beat(1'b0); s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    checks++; if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL cut_through_tvalid: got %b want 1", m_if.tvalid); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL cut_through_empty: got %b want 1", empty); end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (c < 200) begin
        s_valid = ($urandom_range(0, 9) < 8);
        m_ready = ($urandom_range(0, 9) < 4);
      end else begin
        s_valid = ($urandom_range(0, 9) < 4);
        m_ready = ($urandom_range(0, 9) < 8);
      end
      in_beat = rand_beat($urandom_range(0, 3) == 0);
      tick();
      checks++; if (fill_level !== 5'(mdl_q.size())) begin errors++; $display("FAIL rand_fill c%0d: got %0d want %0d", c, fill_level, mdl_q.size()); end
      checks++; if (full !== (mdl_q.size() == DEPTH) || empty !== (mdl_q.size() == 0)) begin errors++; $display("FAIL rand_flags c%0d: got full=%b empty=%b size=%0d", c, full, empty, mdl_q.size()); end
      checks++; if (s_if.tready !== mdl_ready) begin errors++; $display("FAIL rand_tready c%0d: got %b want %b", c, s_if.tready, mdl_ready); end
      checks++; if (m_if.tvalid !== mdl_valid()) begin errors++; $display("FAIL rand_tvalid c%0d: got %b want %b", c, m_if.tvalid, mdl_valid()); end
      if (mdl_valid()) begin
        checks++; if (out_beat !== mdl_q[0]) begin errors++; $display("FAIL rand_beat c%0d: got %h want %h", c, out_beat, mdl_q[0]); end
      end
    end
    s_valid = 1'b0; m_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    beat_t b;
    s_valid = 1'b0; m_ready = 1'b0;
    aresetn = 1'b0; #2; aresetn = 1'b1;
    mdl_q.delete(); mdl_ready = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      in_beat = rand_beat(1'b1); s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    checks++; if (fill_level !== 5'd7) begin errors++; $display("FAIL rstmid_prefill: got %0d want 7", fill_level); end
    #2; aresetn = 1'b0; #1;
    mdl_q.delete(); mdl_ready = 1'b0;
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %b want 0", m_if.tvalid); end
    checks++; if (fill_level !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL rstmid_fill: got fill=%0d empty=%b want 0/1", fill_level, empty); end
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rstmid_tready: got %b want 0", s_if.tready); end
    tick();
    #2; aresetn = 1'b1;
    tick();
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL rstmid_release_tready: got %b want 1", s_if.tready); end
    b = '{data: 32'hC0DE_0007, strb: 4'h3, keep: 4'hC, last: 1'b1, id: 1'b0, dest: 1'b1, user: 1'b0};
    in_beat = b; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    checks++; if (m_if.tvalid !== 1'b1 || out_beat !== b) begin errors++; $display("FAIL rstmid_first_beat: got v=%b %h want v=1 %h", m_if.tvalid, out_beat, b); end
    checks++; if (fill_level !== 5'd1) begin errors++; $display("FAIL rstmid_fill_after: got %0d want 1", fill_level); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_full_and_read();
    test_stream();
`ifdef AXIS_FIFO_PACKET_MODE_EN
    test_packet_mode();
`else
    test_cut_through();
`endif
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
